uart_tx: RTL

UART transmitter: serializes one byte per valid/ready handshake into an 8N1 frame (start bit, 8 data bits LSB first, one stop bit) on a single serial line. It is the transmit counterpart of the board's UART receive path, whose received byte drives the two 7-segment HEX digits. It sits between any byte producer (switches, loopback, test logic) and the board TX pin.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_cnt.sv | 26 ++
 rtl/uart_tx.sv | 83 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings, frame shape.
// Used by both the transmit and receive paths.
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 115_200;
    localparam int DATA_BITS    = 8;
    localparam int STOP_BITS    = 1;
endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// clear holds the count at zero so the first bit starts a full period after release.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);
    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign bit_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            cnt <= '0;
        else if (bit_end)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte input and registered serial output.
// tx falls on the accepting edge; tx_ready and tx_done rise together at frame end.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int BAUD         = DEF_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_done
);
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_t state;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
    logic        bit_end;

    // Counter is held at zero while idle so the accepting edge starts a fresh bit period.
    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shift    <= tx_data;
                        state    <= START;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        bit_idx  <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx      <= shift[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        tx_done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
